seq_ctrl: RTL and testbench

SEQ_CTRL -- requirements
Module: seq_ctrl

---
 rtl/seq_ctrl_pkg.sv | 31 +++
 rtl/seq_stall_wdt.sv | 47 ++++
 rtl/seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_seq_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seq_ctrl_pkg
// Shared parameters for the instruction sequencer: opcode width, the halt
// opcode and the SequencerState encodings. SHALT and SERR sit after the
// original seven-state main path so existing encodings keep their values.
// Also holds a helper that identifies the states able to stall on RAM.
// -----------------------------------------------------------------------------
package seq_ctrl_pkg;

    localparam int unsigned OPCODE_WIDTH = 4;
    localparam logic [OPCODE_WIDTH-1:0] OP_HALT = 4'hF;

    typedef logic [3:0] SequencerState;

    localparam SequencerState SRST   = 4'd0;
    localparam SequencerState SREAD  = 4'd1;
    localparam SequencerState SLOAD1 = 4'd2;
    localparam SequencerState SLOAD2 = 4'd3;
    localparam SequencerState SLOAD3 = 4'd4;
    localparam SequencerState SCALC  = 4'd5;
    localparam SequencerState SWRITE = 4'd6;
    localparam SequencerState SNXT   = 4'd7;
    localparam SequencerState SHALT  = 4'd8;
    localparam SequencerState SERR   = 4'd9;

    // States that wait for RAM while ram_busy is high.
    function automatic logic is_stall_state(input SequencerState s);
        return (s == SLOAD1) || (s == SLOAD2) || (s == SLOAD3) || (s == SCALC);
    endfunction

endpackage

// File: rtl/seq_stall_wdt.sv
// -----------------------------------------------------------------------------
// seq_stall_wdt
// Counts consecutive stalled cycles. trip is raised combinationally during
// the STALL_LIMIT-th consecutive stalled cycle so the sequencer can move to
// its error state on the following clock edge.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset
//   stall - current cycle is a stall cycle
//   clear - current cycle breaks the stall run; count returns to zero
//   trip  - limit reached on this cycle
// -----------------------------------------------------------------------------
module seq_stall_wdt #(
    parameter int unsigned STALL_LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    input  logic clear,
    output logic trip
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // cnt_q holds the number of stalled cycles already completed, so the
    // limit is hit when one more stall arrives with cnt_q at LIMIT-1.
    assign trip = stall && (cnt_q == 8'(STALL_LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (stall) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seq_ctrl.sv
// -----------------------------------------------------------------------------
// seq_ctrl
// Instruction sequencer: SREAD->SLOAD1->SLOAD2->SLOAD3->SCALC->SWRITE->SNXT,
// with RAM stalls in the load/calc stages, run/step/halt control, a stall
// watchdog leading to an absorbing SERR, and optional performance counters.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   run               - free-run level
//   step              - single-step pulse (from SHALT)
//   halt_req          - stop at next instruction boundary (SNXT)
//   opcode            - decoded opcode, valid from SLOAD1
//   ram_busy          - RAM stall indication
//   q                 - registered current state
//   halted, err       - q==SHALT, q==SERR
//   retired_cnt       - SWRITE cycles seen
//   cycle_cnt         - cycles outside SRST/SHALT/SERR
// Build option: define SEQ_PERF_CNT_EN to build the performance counters;
// otherwise both counter outputs are tied to zero.
// -----------------------------------------------------------------------------
module seq_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int unsigned STALL_LIMIT = 16,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic                    step,
    input  logic                    halt_req,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    ram_busy,
    output SequencerState           q,
    output logic                    halted,
    output logic                    err,
    output logic [CNT_WIDTH-1:0]    retired_cnt,
    output logic [CNT_WIDTH-1:0]    cycle_cnt
);

    SequencerState state_q;
    SequencerState state_d;
    logic          step_flag_q;
    logic          step_flag_d;
    logic          stall;
    logic          wdt_clear;
    logic          trip;

    // A halt opcode in SLOAD1 leaves immediately, so it never counts as a stall.
    assign stall     = is_stall_state(state_q) && ram_busy &&
                       !((state_q == SLOAD1) && (opcode == OP_HALT));
    assign wdt_clear = !stall;

    seq_stall_wdt #(
        .STALL_LIMIT(STALL_LIMIT)
    ) u_wdt (
        .clk  (clk),
        .rst  (rst),
        .stall(stall),
        .clear(wdt_clear),
        .trip (trip)
    );

    always_comb begin
        state_d     = state_q;
        step_flag_d = step_flag_q;
        case (state_q)
            SRST: begin
                if (run) begin
                    state_d     = SREAD;
                    step_flag_d = 1'b0;
                end
            end
            SREAD:  state_d = SLOAD1;
            SLOAD1: begin
                if (opcode == OP_HALT) begin
                    state_d     = SHALT;
                    step_flag_d = 1'b0;
                end else if (trip) begin
                    state_d = SERR;
                end else if (!ram_busy) begin
                    state_d = SLOAD2;
                end
            end
            SLOAD2: begin
                if (trip)           state_d = SERR;
                else if (!ram_busy) state_d = SLOAD3;
            end
            SLOAD3: begin
                if (trip)           state_d = SERR;
                else if (!ram_busy) state_d = SCALC;
            end
            SCALC: begin
                if (trip)           state_d = SERR;
                else if (!ram_busy) state_d = SWRITE;
            end
            SWRITE: state_d = SNXT;
            SNXT: begin
                state_d     = (halt_req || step_flag_q) ? SHALT : SREAD;
                step_flag_d = 1'b0;
            end
            SHALT: begin
                // step has priority over resume and marks the instruction
                // so SNXT returns here afterwards.
                if (step) begin
                    state_d     = SREAD;
                    step_flag_d = 1'b1;
                end else if (run && !halt_req) begin
                    state_d     = SREAD;
                    step_flag_d = 1'b0;
                end
            end
            SERR:    state_d = SERR;
            default: state_d = SERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SRST;
            step_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_flag_q <= step_flag_d;
        end
    end

    assign q      = state_q;
    assign halted = (state_q == SHALT);
    assign err    = (state_q == SERR);

`ifdef SEQ_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] retired_q;
    logic [CNT_WIDTH-1:0] retired_d;
    logic [CNT_WIDTH-1:0] cycle_q;
    logic [CNT_WIDTH-1:0] cycle_d;

    always_comb begin
        retired_d = retired_q;
        cycle_d   = cycle_q;
        if (state_q == SWRITE) begin
            retired_d = retired_q + CNT_WIDTH'(1);
        end
        if ((state_q != SRST) && (state_q != SHALT) && (state_q != SERR)) begin
            cycle_d = cycle_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
            cycle_q   <= '0;
        end else begin
            retired_q <= retired_d;
            cycle_q   <= cycle_d;
        end
    end

    assign retired_cnt = retired_q;
    assign cycle_cnt   = cycle_q;
`else
    assign retired_cnt = '0;
    assign cycle_cnt   = '0;
`endif

endmodule

// File: tb/tb_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_ctrl
// Directed bench for seq_ctrl: free-run path, RAM stalls, halt_req, halt
// opcode, single-step, stall watchdog and reset out of SERR. Counter
// expectations follow the SEQ_PERF_CNT_EN build option.
// -----------------------------------------------------------------------------
module tb_seq_ctrl;
    import seq_ctrl_pkg::*;

    localparam int unsigned CW = 16;

`ifdef SEQ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    run;
    logic                    step;
    logic                    halt_req;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic                    ram_busy;
    SequencerState           q;
    logic                    halted;
    logic                    err;
    logic [CW-1:0]           retired_cnt;
    logic [CW-1:0]           cycle_cnt;

    int total = 0;
    int bad   = 0;

    SequencerState path [7] = '{SREAD, SLOAD1, SLOAD2, SLOAD3, SCALC, SWRITE, SNXT};

    always #5 clk = ~clk;

    seq_ctrl #(
        .STALL_LIMIT(16),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .step       (step),
        .halt_req   (halt_req),
        .opcode     (opcode),
        .ram_busy   (ram_busy),
        .q          (q),
        .halted     (halted),
        .err        (err),
        .retired_cnt(retired_cnt),
        .cycle_cnt  (cycle_cnt)
    );

    function automatic logic [31:0] exp_cnt(input int n);
        return PERF ? 32'(n) : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_q(input string tag, input SequencerState e);
        chk(tag, 32'(q), 32'(e));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0;
        ram_busy = 1'b0; opcode = '0;
        cyc(2);
        chk_q("rst_q", SRST);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_retired", 32'(retired_cnt), 32'd0);
        chk("rst_cycle", 32'(cycle_cnt), 32'd0);

        rst = 1'b0;
        cyc(1);
        chk_q("srst_hold", SRST);

        // Free run, three instructions, 7-cycle period.
        run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            opcode = OPCODE_WIDTH'(i + 1);
            for (int s = 0; s < 7; s++) begin
                cyc(1);
                chk_q($sformatf("free_i%0d_s%0d", i, s), path[s]);
            end
            chk($sformatf("free_retired_i%0d", i), 32'(retired_cnt), exp_cnt(i + 1));
        end
        chk("free_cycle", 32'(cycle_cnt), exp_cnt(20));
        chk("free_halted", 32'(halted), 32'd0);

        // Four stall cycles in SLOAD2.
        cyc(1); chk_q("st_read", SREAD);
        cyc(1); chk_q("st_load1", SLOAD1);
        cyc(1); chk_q("st_load2", SLOAD2);
        ram_busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            chk_q($sformatf("st_hold%0d", k), SLOAD2);
        end
        ram_busy = 1'b0;
        cyc(1); chk_q("st_load3", SLOAD3);
        cyc(1); chk_q("st_calc", SCALC);
        cyc(1); chk_q("st_write", SWRITE);
        cyc(1); chk_q("st_nxt", SNXT);
        chk("st_err", 32'(err), 32'd0);
        chk("st_retired", 32'(retired_cnt), exp_cnt(4));

        // halt_req raised mid-instruction: completes, then SHALT.
        cyc(1); chk_q("hr_read", SREAD);
        cyc(1); chk_q("hr_load1", SLOAD1);
        cyc(1); chk_q("hr_load2", SLOAD2);
        cyc(1); chk_q("hr_load3", SLOAD3);
        halt_req = 1'b1;
        cyc(1); chk_q("hr_calc", SCALC);
        cyc(1); chk_q("hr_write", SWRITE);
        cyc(1); chk_q("hr_nxt", SNXT);
        cyc(1); chk_q("hr_halt", SHALT);
        chk("hr_halted", 32'(halted), 32'd1);
        chk("hr_retired", 32'(retired_cnt), exp_cnt(5));
        cyc(1); chk_q("hr_hold_runhalt", SHALT);

        // step and resume both valid: single-step wins.
        halt_req = 1'b0;
        step = 1'b1;
        cyc(1); chk_q("ss_read", SREAD);
        step = 1'b0;
        for (int s = 1; s < 7; s++) begin
            cyc(1);
            chk_q($sformatf("ss_s%0d", s), path[s]);
        end
        run = 1'b0;
        cyc(1); chk_q("ss_back_halt", SHALT);
        chk("ss_retired", 32'(retired_cnt), exp_cnt(6));
        cyc(1); chk_q("ss_hold", SHALT);

        // Halt opcode in SLOAD1, with ram_busy high to show priority.
        run = 1'b1;
        cyc(1); chk_q("ho_read", SREAD);
        opcode = OP_HALT;
        ram_busy = 1'b1;
        cyc(1); chk_q("ho_load1", SLOAD1);
        run = 1'b0;
        cyc(1); chk_q("ho_halt", SHALT);
        chk("ho_halted", 32'(halted), 32'd1);
        chk("ho_retired", 32'(retired_cnt), exp_cnt(6));
        opcode = 4'h3;
        ram_busy = 1'b0;
        cyc(1); chk_q("ho_hold", SHALT);
        step = 1'b1;
        cyc(1); chk_q("ho_step_read", SREAD);
        step = 1'b0;
        for (int s = 1; s < 7; s++) begin
            cyc(1);
            chk_q($sformatf("ho_step_s%0d", s), path[s]);
        end
        cyc(1); chk_q("ho_step_halt", SHALT);
        chk("ho_step_retired", 32'(retired_cnt), exp_cnt(7));

        // Watchdog: 15 stalls then release is safe; 16 stalls trips.
        run = 1'b1;
        cyc(1); chk_q("wd_read", SREAD);
        cyc(1); chk_q("wd_load1", SLOAD1);
        cyc(1); chk_q("wd_load2", SLOAD2);
        ram_busy = 1'b1;
        for (int k = 0; k < 15; k++) begin
            cyc(1);
            chk_q($sformatf("wd15_hold%0d", k), SLOAD2);
        end
        ram_busy = 1'b0;
        cyc(1); chk_q("wd_load3", SLOAD3);
        chk("wd15_err", 32'(err), 32'd0);
        cyc(1); chk_q("wd_calc", SCALC);
        ram_busy = 1'b1;
        for (int k = 0; k < 15; k++) begin
            cyc(1);
            chk_q($sformatf("wd16_hold%0d", k), SCALC);
        end
        cyc(1); chk_q("wd_serr", SERR);
        chk("wd_err", 32'(err), 32'd1);
        chk("wd_halted", 32'(halted), 32'd0);
        ram_busy = 1'b0;
        step = 1'b1;
        cyc(3); chk_q("wd_absorb", SERR);
        chk("wd_err_sticky", 32'(err), 32'd1);
        step = 1'b0;

        // Reset exits SERR.
        rst = 1'b1;
        cyc(1); chk_q("rst2_q", SRST);
        chk("rst2_err", 32'(err), 32'd0);
        chk("rst2_retired", 32'(retired_cnt), 32'd0);
        chk("rst2_cycle", 32'(cycle_cnt), 32'd0);
        rst = 1'b0;
        run = 1'b0;
        cyc(1); chk_q("rst2_hold", SRST);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
